result_encoder: RTL and testbench

//  Response-side counterpart of the UART calculator command parser: takes a computed result
//  and serializes it into an ASCII response frame, one byte at a time, to the UART transmitter.

---
 rtl/result_encoder.sv | 186 ++++++++++++++++++
 tb/tb_result_encoder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/result_encoder.sv
// Serializes an ALU result into an ASCII response frame for uart_tx: 'O', type, [sign], digits, CR, LF.
// Build option RESULT_ENC_LZS_EN enables leading-zero suppression of decimal digits.
module result_encoder #(
    parameter int RES_W      = 16,
    parameter int DEC_DIGITS = 5
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [RES_W-1:0] result,
    input  logic             result_err,
    input  logic [3:0]       dtype,
    input  logic             result_valid,
    output logic             result_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             enc_done
);

    // state | meaning
    // IDLE  | waiting for a request, result_ready high
    // CONV  | double-dabble binary to BCD, RES_W cycles
    // HDR_O | sending 'O'
    // HDR_T | sending type echo 'S' or 'W'
    // SIGN  | sending '-' (negative decimal only)
    // DIGIT | sending digits MSB-first
    // ERR   | sending 'E'
    // CR    | sending carriage return
    // LF    | sending line feed

`ifdef RESULT_ENC_LZS_EN
    localparam bit LZS = 1'b1;
`else
    localparam bit LZS = 1'b0;
`endif

    localparam int CNT_W = $clog2(RES_W + 1);
    localparam int IDX_W = 8;
    localparam int BCD_W = DEC_DIGITS * 4;

    typedef enum logic [3:0] {
        IDLE, CONV, HDR_O, HDR_T, SIGN, DIGIT, ERR, CR, LF
    } state_t;

    state_t             state_q, state_d;
    logic [RES_W-1:0]   data_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   conv_cnt;
    logic [IDX_W-1:0]   dig_idx;
    logic               dec_q, neg_q, err_q;
    logic               accept, xfer;
    logic               req_err, req_dec;
    logic [RES_W:0]     ext, mag;
    logic [BCD_W-1:0]   bcd_adj;
    logic [IDX_W-1:0]   lead_idx;
    logic [RES_W-1:0]   hex_sh;
    logic [BCD_W-1:0]   bcd_sh;
    logic [3:0]         nib;

    assign accept  = result_valid && result_ready;
    assign xfer    = tx_valid && tx_ready;
    assign req_dec = (dtype == 4'h1);
    assign req_err = result_err || !(dtype == 4'h1 || dtype == 4'h2);

    // One extra bit so the most negative value negates to its true magnitude
    assign ext = {result[RES_W-1], result};
    assign mag = result[RES_W-1] ? (~ext + 1'b1) : ext;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DEC_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < DEC_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] != 4'd0)
                lead_idx = IDX_W'(i);
        end
    end

    assign hex_sh = data_q >> {dig_idx, 2'b00};
    assign bcd_sh = bcd_q >> {dig_idx, 2'b00};
    assign nib    = dec_q ? bcd_sh[3:0] : hex_sh[3:0];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        result_ready = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        case (state_q)
            IDLE: begin
                result_ready = 1'b1;
                if (result_valid) begin
                    if (req_err)      state_d = HDR_O;
                    else if (req_dec) state_d = CONV;
                    else              state_d = HDR_O;
                end
            end
            CONV: begin
                if (conv_cnt == CNT_W'(1)) state_d = HDR_O;
            end
            HDR_O: begin
                tx_valid = 1'b1;
                tx_data  = 8'h4F;
                if (tx_ready) state_d = err_q ? ERR : HDR_T;
            end
            HDR_T: begin
                tx_valid = 1'b1;
                tx_data  = dec_q ? 8'h53 : 8'h57;
                if (tx_ready) state_d = (dec_q && neg_q) ? SIGN : DIGIT;
            end
            SIGN: begin
                tx_valid = 1'b1;
                tx_data  = 8'h2D;
                if (tx_ready) state_d = DIGIT;
            end
            DIGIT: begin
                tx_valid = 1'b1;
                tx_data  = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
                if (tx_ready && dig_idx == '0) state_d = CR;
            end
            ERR: begin
                tx_valid = 1'b1;
                tx_data  = 8'h45;
                if (tx_ready) state_d = CR;
            end
            CR: begin
                tx_valid = 1'b1;
                tx_data  = 8'h0D;
                if (tx_ready) state_d = LF;
            end
            LF: begin
                tx_valid = 1'b1;
                tx_data  = 8'h0A;
                if (tx_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_q   <= '0;
            bcd_q    <= '0;
            conv_cnt <= '0;
            dig_idx  <= '0;
            dec_q    <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            enc_done <= 1'b0;
        end else begin
            enc_done <= (state_q == LF) && xfer;
            if (accept) begin
                err_q    <= req_err;
                dec_q    <= req_dec;
                neg_q    <= req_dec && result[RES_W-1];
                data_q   <= req_dec ? mag[RES_W-1:0] : result;
                bcd_q    <= '0;
                conv_cnt <= CNT_W'(RES_W);
            end
            if (state_q == CONV) begin
                bcd_q    <= {bcd_adj[BCD_W-2:0], data_q[RES_W-1]};
                data_q   <= {data_q[RES_W-2:0], 1'b0};
                conv_cnt <= conv_cnt - 1'b1;
            end
            // Digit index is chosen once BCD is final; with suppression start at the first non-zero
            if (state_q == HDR_T && xfer) begin
                if (!dec_q)   dig_idx <= IDX_W'(RES_W/4 - 1);
                else if (LZS) dig_idx <= lead_idx;
                else          dig_idx <= IDX_W'(DEC_DIGITS - 1);
            end
            if (state_q == DIGIT && xfer && dig_idx != '0)
                dig_idx <= dig_idx - 1'b1;
        end
    end

endmodule

// File: tb/tb_result_encoder.sv
// Directed self-checking bench for result_encoder (RES_W=16, DEC_DIGITS=5), both LZS builds.
module tb_result_encoder;

    logic        clk;
    logic        n_rst;
    logic [15:0] result;
    logic        result_err;
    logic [3:0]  dtype;
    logic        result_valid;
    logic        result_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        enc_done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] exp_b [16];
    int         exp_n;
    logic [7:0] got_b [32];
    int         got_n;

    result_encoder #(.RES_W(16), .DEC_DIGITS(5)) dut (
        .clk(clk), .n_rst(n_rst), .result(result), .result_err(result_err),
        .dtype(dtype), .result_valid(result_valid), .result_ready(result_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .enc_done(enc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic load_exp(input logic [127:0] bytes, input int n);
        exp_n = n;
        for (int i = 0; i < n; i++) exp_b[i] = bytes[8*(n-1-i) +: 8];
    endtask

    // Issue one request and collect the frame until enc_done; compares bytes and latency
    task automatic send(input string tag, input logic [3:0] dt, input logic err,
                        input logic [15:0] res, input int exp_lat, input bit stall);
        int  lat;
        int  first_lat;
        bit  done_seen;
        bit  stalled;
        logic [7:0] held;
        @(negedge clk);
        result = res; result_err = err; dtype = dt; result_valid = 1'b1; tx_ready = 1'b1;
        chk({tag, "_ready"}, result_ready, 1);
        @(negedge clk);
        result_valid = 1'b0;
        lat = 1; first_lat = -1; done_seen = 0; stalled = 0; got_n = 0; held = 8'h00;
        while (!done_seen && lat < 400) begin
            result_valid = stall && tx_valid && ($urandom_range(0, 1) == 1);
            tx_ready     = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (enc_done) begin
                done_seen = 1;
                chk({tag, "_rdy_at_done"}, result_ready, 1);
                chk({tag, "_txv_at_done"}, tx_valid, 0);
            end else if (tx_valid) begin
                if (first_lat < 0) first_lat = lat;
                if (stalled) chk({tag, "_stable"}, tx_data, held);
                if (tx_ready) begin
                    if (got_n < 32) got_b[got_n] = tx_data;
                    got_n++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = tx_data;
                end
            end
            @(negedge clk);
            lat++;
        end
        result_valid = 1'b0;
        tx_ready = 1'b1;
        chk({tag, "_done_seen"}, done_seen, 1);
        chk({tag, "_latency"}, first_lat, exp_lat);
        chk({tag, "_count"}, got_n, exp_n);
        for (int i = 0; i < exp_n && i < got_n; i++)
            chk($sformatf("%s_byte%0d", tag, i), got_b[i], exp_b[i]);
    endtask

    initial begin
        n_rst = 1'b0; result = '0; result_err = 1'b0; dtype = 4'h0;
        result_valid = 1'b0; tx_ready = 1'b1;
        #12;
        chk("rst_ready", result_ready, 1);
        chk("rst_txv", tx_valid, 0);
        chk("rst_txd", tx_data, 8'h00);
        chk("rst_done", enc_done, 0);
        @(negedge clk); n_rst = 1'b1;

        load_exp(128'h4F57_3141_3246_0D0A, 8);
        send("hex", 4'h2, 1'b0, 16'h1A2F, 1, 0);

`ifdef RESULT_ENC_LZS_EN
        load_exp(128'h4F53_2D31_3233_0D0A, 8);
`else
        load_exp(128'h4F53_2D30_3031_3233_0D0A, 10);
`endif
        send("neg123", 4'h1, 1'b0, 16'hFF85, 17, 0);

`ifdef RESULT_ENC_LZS_EN
        load_exp(128'h4F53_300D_0A, 5);
`else
        load_exp(128'h4F53_3030_3030_300D_0A, 9);
`endif
        send("zero", 4'h1, 1'b0, 16'h0000, 17, 0);

        load_exp(128'h4F53_2D33_3237_3638_0D0A, 10);
        send("minval", 4'h1, 1'b0, 16'h8000, 17, 0);

`ifdef RESULT_ENC_LZS_EN
        load_exp(128'h4F53_3332_3736_370D_0A, 9);
`else
        load_exp(128'h4F53_3332_3736_370D_0A, 9);
`endif
        send("maxpos", 4'h1, 1'b0, 16'h7FFF, 17, 0);

        load_exp(128'h4F45_0D0A, 4);
        send("err_flag", 4'h1, 1'b1, 16'h1234, 1, 0);
        send("err_dtype", 4'h7, 1'b0, 16'h1234, 1, 0);

        load_exp(128'h4F57_3141_3246_0D0A, 8);
        send("hex_stall", 4'h2, 1'b0, 16'h1A2F, 1, 1);
        repeat (3) @(negedge clk);
        chk("drop_txv", tx_valid, 0);
        chk("drop_ready", result_ready, 1);

        @(negedge clk);
        result = 16'h1A2F; dtype = 4'h2; result_err = 1'b0; result_valid = 1'b1;
        @(negedge clk); result_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_txv", tx_valid, 1);
        #2 n_rst = 1'b0;
        #1;
        chk("abort_txv", tx_valid, 0);
        chk("abort_done", enc_done, 0);
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", result_ready, 1);
        chk("post_rst_txv", tx_valid, 0);
        load_exp(128'h4F57_3141_3246_0D0A, 8);
        send("after_rst", 4'h2, 1'b0, 16'h1A2F, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
